// File: rtl/alu_pipe_pkg.sv
// Shared constants for alu_pipe: function codes, unit-tag one-hots, FSM state type.
// The DIV state exists only when ALU_DIV_EN is defined.
package alu_pipe_pkg;

  localparam logic [3:0] FN_ADD    = 4'b0000;
  localparam logic [3:0] FN_SUB    = 4'b0001;
  localparam logic [3:0] FN_MUL    = 4'b0010;
  localparam logic [3:0] FN_DIV    = 4'b0011;
  localparam logic [3:0] FN_AND    = 4'b0100;
  localparam logic [3:0] FN_OR     = 4'b0101;
  localparam logic [3:0] FN_NAND   = 4'b0110;
  localparam logic [3:0] FN_NOR    = 4'b0111;
  localparam logic [3:0] FN_XOR    = 4'b1000;
  localparam logic [3:0] FN_XNOR   = 4'b1001;
  localparam logic [3:0] FN_CMP_EQ = 4'b1010;
  localparam logic [3:0] FN_CMP_GT = 4'b1011;
  localparam logic [3:0] FN_CMP_LT = 4'b1100;
  localparam logic [3:0] FN_SHR_A  = 4'b1101;
  localparam logic [3:0] FN_SHL_A  = 4'b1110;
  localparam logic [3:0] FN_SHR_B  = 4'b1111;

  // unit tag order is {shift, cmp, logic, arith}
  localparam logic [3:0] UF_ARITH = 4'b0001;
  localparam logic [3:0] UF_LOGIC = 4'b0010;
  localparam logic [3:0] UF_CMP   = 4'b0100;
  localparam logic [3:0] UF_SHIFT = 4'b1000;

`ifdef ALU_DIV_EN
  typedef enum logic {ST_IDLE = 1'b0, ST_DIV = 1'b1} state_t;
`else
  typedef enum logic {ST_IDLE = 1'b0} state_t;
`endif

endpackage

// File: rtl/alu_div_seq.sv
// Signed restoring divider: WIDTH iterations on magnitudes, then sign fix-up
// (quotient truncates toward zero, remainder follows the dividend's sign).
module alu_div_seq #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stall,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    done,
  output logic [WIDTH-1:0]        quot,
  output logic [WIDTH-1:0]        rem
);
  localparam int CW = $clog2(WIDTH);

  logic             busy, neg_q, neg_r, last, ge;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_r, r_r, d_r, q_nx, r_nx;
  logic [WIDTH:0]   shifted, diff;

  assign shifted = {r_r, q_r[WIDTH-1]};
  assign diff    = shifted - {1'b0, d_r};
  assign ge      = !diff[WIDTH];
  assign r_nx    = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign q_nx    = {q_r[WIDTH-2:0], ge};
  assign last    = (cnt == CW'(WIDTH - 1));
  // The final step is presented combinationally so the result lands on the
  // same edge as the last iteration; it waits while the output is blocked.
  assign done    = busy && last && !stall;
  assign quot    = neg_q ? -q_nx : q_nx;
  assign rem     = neg_r ? -r_nx : r_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      q_r   <= '0;
      r_r   <= '0;
      d_r   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      q_r   <= a[WIDTH-1] ? -a : a;
      d_r   <= b[WIDTH-1] ? -b : b;
      r_r   <= '0;
      neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r <= a[WIDTH-1];
    end else if (busy && !(last && stall)) begin
      q_r <= q_nx;
      r_r <= r_nx;
      cnt <= last ? '0 : cnt + CW'(1);
      if (last) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked 16-function ALU with one registered result stage.
// Define ALU_DIV_EN to compile in the iterative signed divider and DIV state.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 2 * WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH-1:0]     A,
  input  logic signed [WIDTH-1:0]     B,
  input  logic [3:0]                  ALU_FUN,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_WIDTH-1:0]        RESULT,
  output logic                        Carry_OUT,
  output logic [3:0]                  UNIT_Flag,
  output logic                        ERR
);
  localparam int PAD = OUT_WIDTH - WIDTH;

  state_t                       state, state_nx;
  logic                         accept, div_start, div_done;
  logic [WIDTH-1:0]             div_q, div_r, lw;
  logic signed [WIDTH:0]        sum, dif;
  logic signed [OUT_WIDTH-1:0]  prod;
  logic [OUT_WIDTH-1:0]         res_c;
  logic                         carry_c, err_c;
  logic [3:0]                   flag_c;

  assign accept = in_valid && in_ready;

`ifdef ALU_DIV_EN
  assign div_start = accept && (ALU_FUN == FN_DIV) && (B != '0);

  alu_div_seq #(.WIDTH(WIDTH)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .stall (out_valid && !out_ready),
    .a     (A),
    .b     (B),
    .done  (div_done),
    .quot  (div_q),
    .rem   (div_r)
  );
`else
  assign div_start = 1'b0;
  assign div_done  = 1'b0;
  assign div_q     = '0;
  assign div_r     = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
`ifdef ALU_DIV_EN
    if (state == ST_IDLE && div_start)    state_nx = ST_DIV;
    else if (state == ST_DIV && div_done) state_nx = ST_IDLE;
`endif
  end

  always_comb begin
    in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  end

  assign sum  = {A[WIDTH-1], A} + {B[WIDTH-1], B};
  assign dif  = {A[WIDTH-1], A} - {B[WIDTH-1], B};
  assign prod = A * B;

  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    flag_c  = UF_ARITH;
    err_c   = 1'b0;
    lw      = '0;
    case (ALU_FUN)
      FN_ADD: begin
        res_c   = {{(PAD-1){sum[WIDTH]}}, sum};
        // unsigned carry out of the MSB, rebuilt from the signed sum bit
        carry_c = (A[WIDTH-1] & B[WIDTH-1]) | ((A[WIDTH-1] ^ B[WIDTH-1]) & ~sum[WIDTH-1]);
      end
      FN_SUB: begin
        res_c   = {{(PAD-1){dif[WIDTH]}}, dif};
        carry_c = $unsigned(A) < $unsigned(B);
      end
      FN_MUL: res_c = prod;
`ifdef ALU_DIV_EN
      FN_DIV: err_c = (B == '0);
`else
      FN_DIV: err_c = 1'b1;
`endif
      FN_AND, FN_OR, FN_NAND, FN_NOR, FN_XOR, FN_XNOR: begin
        flag_c = UF_LOGIC;
        case (ALU_FUN)
          FN_AND:  lw = A & B;
          FN_OR:   lw = A | B;
          FN_NAND: lw = ~(A & B);
          FN_NOR:  lw = ~(A | B);
          FN_XOR:  lw = A ^ B;
          default: lw = ~(A ^ B);
        endcase
        res_c = {{PAD{1'b0}}, lw};
      end
      FN_CMP_EQ: begin flag_c = UF_CMP; res_c = (A == B) ? OUT_WIDTH'(1) : '0; end
      FN_CMP_GT: begin flag_c = UF_CMP; res_c = (A > B)  ? OUT_WIDTH'(2) : '0; end
      FN_CMP_LT: begin flag_c = UF_CMP; res_c = (A < B)  ? OUT_WIDTH'(3) : '0; end
      default: begin
        flag_c = UF_SHIFT;
        case (ALU_FUN)
          FN_SHR_A: lw = {1'b0, A[WIDTH-1:1]};
          FN_SHL_A: lw = {A[WIDTH-2:0], 1'b0};
          default:  lw = {B[WIDTH-1], B[WIDTH-1:1]};
        endcase
        res_c = {{PAD{1'b0}}, lw};
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      RESULT    <= '0;
      Carry_OUT <= 1'b0;
      UNIT_Flag <= '0;
      ERR       <= 1'b0;
    end else if (accept && !div_start) begin
      out_valid <= 1'b1;
      RESULT    <= res_c;
      Carry_OUT <= carry_c;
      UNIT_Flag <= flag_c;
      ERR       <= err_c;
    end else if (div_done) begin
      out_valid <= 1'b1;
      RESULT    <= {div_r, div_q};
      Carry_OUT <= 1'b0;
      UNIT_Flag <= UF_ARITH;
      ERR       <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe; DIV scenarios follow ALU_DIV_EN.
module tb_alu_pipe;
  localparam int W  = 16;
  localparam int OW = 32;

  typedef struct packed {
    logic [OW-1:0] res;
    logic          carry;
    logic [3:0]    flag;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  A, B;
  logic [3:0]    ALU_FUN;
  logic [OW-1:0] RESULT;
  logic          Carry_OUT, ERR;
  logic [3:0]    UNIT_Flag;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_FUN(ALU_FUN), .out_valid(out_valid), .out_ready(out_ready),
    .RESULT(RESULT), .Carry_OUT(Carry_OUT), .UNIT_Flag(UNIT_Flag), .ERR(ERR)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sb, ua, ub, r;
    logic [W-1:0] w;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a);          ub = longint'(b);
    e = '0; r = 0; w = '0;
    case (f)
      4'h0: begin r = sa + sb; e.res = r[OW-1:0]; e.carry = ((ua + ub) >> W) != 0; e.flag = 4'b0001; end
      4'h1: begin r = sa - sb; e.res = r[OW-1:0]; e.carry = ua < ub; e.flag = 4'b0001; end
      4'h2: begin r = sa * sb; e.res = r[OW-1:0]; e.flag = 4'b0001; end
      4'h3: begin
        e.flag = 4'b0001;
`ifdef ALU_DIV_EN
        if (sb == 0) e.err = 1'b1;
        else begin
          longint q, m;
          q = sa / sb; m = sa % sb;
          e.res = {m[W-1:0], q[W-1:0]};
        end
`else
        e.err = 1'b1;
`endif
      end
      4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
        case (f)
          4'h4: w = a & b;
          4'h5: w = a | b;
          4'h6: w = ~(a & b);
          4'h7: w = ~(a | b);
          4'h8: w = a ^ b;
          default: w = ~(a ^ b);
        endcase
        e.res = {{(OW-W){1'b0}}, w}; e.flag = 4'b0010;
      end
      4'hA: begin e.res = (sa == sb) ? 1 : 0; e.flag = 4'b0100; end
      4'hB: begin e.res = (sa >  sb) ? 2 : 0; e.flag = 4'b0100; end
      4'hC: begin e.res = (sa <  sb) ? 3 : 0; e.flag = 4'b0100; end
      default: begin
        if (f == 4'hD)      r = ua >> 1;
        else if (f == 4'hE) r = ua << 1;
        else                r = sb >>> 1;
        w = r[W-1:0];
        e.res = {{(OW-W){1'b0}}, w}; e.flag = 4'b1000;
      end
    endcase
    return e;
  endfunction

  // every consumed result is checked against the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output got res=%h", RESULT);
      end else begin
        mon_e = sbq.pop_front();
        if ({RESULT, Carry_OUT, UNIT_Flag, ERR} !== mon_e) begin
          failures++;
          $display("FAIL scoreboard got res=%h c=%b f=%b e=%b want res=%h c=%b f=%b e=%b",
                   RESULT, Carry_OUT, UNIT_Flag, ERR, mon_e.res, mon_e.carry, mon_e.flag, mon_e.err);
        end
      end
    end
  end

  // drives one op and returns one clock after it is accepted (in_valid left high)
  task automatic send(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b, output int waits);
    in_valid = 1'b1; ALU_FUN = f; A = a; B = b; waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 200) begin waits++; @(negedge clk); end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout fun=%h got in_ready=0 want 1", f);
    end else sbq.push_back(model(f, a, b));
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; ALU_FUN = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, RESULT, Carry_OUT, UNIT_Flag, ERR} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b res=%h c=%b f=%b e=%b want all 0",
               out_valid, RESULT, Carry_OUT, UNIT_Flag, ERR);
    end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_arith;
    int w;
    out_ready = 1'b1;
    send(4'h0, 16'h7FFF, 16'h0001, w);
    checks++;
    if (out_valid !== 1'b1 || RESULT !== 32'h0000_8000 || Carry_OUT !== 1'b0 || UNIT_Flag !== 4'b0001) begin
      failures++;
      $display("FAIL add_latency1 got v=%b res=%h c=%b f=%b want 1 00008000 0 0001",
               out_valid, RESULT, Carry_OUT, UNIT_Flag);
    end
    send(4'h1, 16'h0001, 16'h0002, w);
    checks++;
    if (RESULT !== 32'hFFFF_FFFF || Carry_OUT !== 1'b1) begin
      failures++; $display("FAIL sub_borrow got res=%h c=%b want ffffffff 1", RESULT, Carry_OUT);
    end
    send(4'h2, 16'hFFFD, 16'h0007, w);
    checks++;
    if (RESULT !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_neg got %h want ffffffeb", RESULT); end
    send(4'h0, 16'hFFFF, 16'h0001, w);
    send(4'h0, 16'h8000, 16'h8000, w);
    send(4'h1, 16'h8000, 16'h0001, w);
    send(4'h2, 16'h8000, 16'h8000, w);
    idle(2);
  endtask

  task automatic test_back_to_back;
    int w, total;
    total = 0;
    out_ready = 1'b1;
    for (int f = 4; f < 16; f++) begin
      send(4'(f), 16'($urandom), 16'($urandom), w);
      total += w;
    end
    send(4'hA, 16'h1234, 16'h1234, w); total += w;
    send(4'hB, 16'h8000, 16'h7FFF, w); total += w;
    send(4'hC, 16'h8000, 16'h7FFF, w); total += w;
    send(4'hF, 16'h8001, 16'h8001, w); total += w;
    checks++;
    if (total !== 0) begin failures++; $display("FAIL back_to_back_stalls got %0d want 0", total); end
    idle(2);
  endtask

  task automatic test_div;
    int w, lowc;
`ifdef ALU_DIV_EN
    out_ready = 1'b1;
    send(4'h3, 16'hFFF9, 16'h0002, w);
    in_valid = 1'b0;
    lowc = 0;
    @(negedge clk);
    while (!in_ready && lowc < 100) begin lowc++; @(negedge clk); end
    checks++;
    if (lowc !== W) begin failures++; $display("FAIL div_busy_cycles got %0d want %0d", lowc, W); end
    checks++;
    if (out_valid !== 1'b1 || RESULT !== 32'hFFFF_FFFD || ERR !== 1'b0) begin
      failures++; $display("FAIL div_result got v=%b res=%h e=%b want 1 fffffffd 0", out_valid, RESULT, ERR);
    end
    @(posedge clk); #1;
    send(4'h3, 16'h8000, 16'hFFFF, w);
    send(4'h3, 16'd100, 16'hFFF9, w);
    send(4'h3, 16'h1234, 16'h0000, w);
    send(4'h0, 16'h0001, 16'h0001, w);
    in_valid = 1'b0;
    checks++;
    if (w !== 0) begin failures++; $display("FAIL div_zero_single_cycle got waits=%0d want 0", w); end
    idle(30);
`else
    out_ready = 1'b1;
    send(4'h3, 16'd10, 16'd2, w);
    checks++;
    if (out_valid !== 1'b1 || RESULT !== 32'h0 || ERR !== 1'b1 || UNIT_Flag !== 4'b0001) begin
      failures++; $display("FAIL nodiv_err got v=%b res=%h e=%b f=%b want 1 0 1 0001", out_valid, RESULT, ERR, UNIT_Flag);
    end
    send(4'h3, 16'h0000, 16'h0000, w);
    idle(2);
`endif
  endtask

  task automatic test_backpressure;
    int w;
    idle(2);
    out_ready = 1'b0;
    send(4'hB, 16'd5, 16'd3, w);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || RESULT !== 32'd2 || UNIT_Flag !== 4'b0100 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got v=%b res=%h f=%b rdy=%b want 1 2 0100 0",
                 i, out_valid, RESULT, UNIT_Flag, in_ready);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4'hE, 16'h8001, 16'h0000, w);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || RESULT !== 32'h0000_0002 || UNIT_Flag !== 4'b1000) begin
      failures++; $display("FAIL bp_drain_accept got v=%b res=%h f=%b want 1 2 1000", out_valid, RESULT, UNIT_Flag);
    end
    idle(2);
  endtask

  task automatic test_reset_mid;
    int w, stale;
`ifdef ALU_DIV_EN
    out_ready = 1'b1;
    send(4'h3, 16'd100, 16'd3, w);
`else
    out_ready = 1'b0;
    send(4'h0, 16'd100, 16'd3, w);
`endif
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    sbq.delete();
    checks++;
    if ({out_valid, RESULT, Carry_OUT, UNIT_Flag, ERR} !== '0) begin
      failures++; $display("FAIL rst_mid_outputs got v=%b res=%h want 0", out_valid, RESULT);
    end
    @(negedge clk); rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
    stale = 0;
    repeat (25) begin @(negedge clk); if (out_valid) stale++; end
    checks++;
    if (stale !== 0) begin failures++; $display("FAIL rst_mid_stale got %0d valid cycles want 0", stale); end
    @(posedge clk); #1;
    send(4'h0, 16'h0005, 16'h0006, w);
    idle(3);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; ALU_FUN = '0;
    test_reset();
    test_arith();
    test_back_to_back();
    test_div();
    test_backpressure();
    test_reset_mid();
    checks++;
    if (sbq.size() !== 0) begin failures++; $display("FAIL scoreboard_drain got %0d left want 0", sbq.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
